// File: rtl/demux_pkg.sv
// demux_pkg: slot codes shared by the 1:4 write-side demux and the 4:1 result mux.
//   CH_A..CH_D     2-bit destination codes (note B and C are bit-swapped vs. binary order)
//   DEFAULT_WIDTH  default datapath width
//   ch_decode()    code -> one-hot slot select, bit 0 = A .. bit 3 = D
package demux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b10;
    localparam logic [1:0] CH_C = 2'b01;
    localparam logic [1:0] CH_D = 2'b11;

    function automatic logic [3:0] ch_decode(input logic [1:0] code);
        logic [3:0] oh;
        oh = 4'b0000;
        unique case (code)
            CH_A:    oh = 4'b0001;
            CH_B:    oh = 4'b0010;
            CH_C:    oh = 4'b0100;
            CH_D:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register with full flag and delivered-word counter.
//   clk, rst_n   clock, async active-low reset
//   load         write in_data this cycle (caller guarantees room: !full | out_ready)
//   in_data      word to store
//   out_ready    consumer takes the held word this cycle
//   out_valid    slot holds a word
//   out_data     held word (keeps last value after drain)
//   cnt          number of drains, wraps silently
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] cnt
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drain;

    assign drain = full_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            // Load wins over drain so a same-cycle drain+load keeps the slot full.
            if (load) begin
                full_q <= 1'b1;
                data_q <= in_data;
            end else if (drain) begin
                full_q <= 1'b0;
            end
            if (drain) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/demux1x4_buf.sv
// demux1x4_buf: registered 1:4 demux with valid/ready, routing one input word per cycle
// into one of four one-entry slots selected by ctrl (A=00, B=10, C=01, D=11).
//   clk, rst_n                 clock, async active-low reset
//   ctrl, in_valid, in_data    input channel; in_ready = selected slot can take a word
//   out_valid_x, out_data_x    slot x contents
//   out_ready_x                consumer x takes its word
//   cnt_x                      words delivered from slot x
//   busy                       any slot holds a word
module demux1x4_buf
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ctrl,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid_a,
    output logic             out_valid_b,
    output logic             out_valid_c,
    output logic             out_valid_d,
    output logic [WIDTH-1:0] out_data_a,
    output logic [WIDTH-1:0] out_data_b,
    output logic [WIDTH-1:0] out_data_c,
    output logic [WIDTH-1:0] out_data_d,
    input  logic             out_ready_a,
    input  logic             out_ready_b,
    input  logic             out_ready_c,
    input  logic             out_ready_d,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d,
    output logic             busy
);

    logic [3:0] sel;
    logic [3:0] full;
    logic [3:0] rdy;
    logic [3:0] load;
    logic       accept;

    assign sel  = ch_decode(ctrl);
    assign full = {out_valid_d, out_valid_c, out_valid_b, out_valid_a};
    assign rdy  = {out_ready_d, out_ready_c, out_ready_b, out_ready_a};

    // Combinational through ctrl and the selected out_ready: a slot draining this cycle
    // can take a new word in the same cycle.
    assign in_ready = |(sel & (~full | rdy));
    assign accept   = in_valid & in_ready;
    assign load     = sel & {4{accept}};
    assign busy     = |full;

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[0]),
        .in_data   (in_data),
        .out_ready (out_ready_a),
        .out_valid (out_valid_a),
        .out_data  (out_data_a),
        .cnt       (cnt_a)
    );

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[1]),
        .in_data   (in_data),
        .out_ready (out_ready_b),
        .out_valid (out_valid_b),
        .out_data  (out_data_b),
        .cnt       (cnt_b)
    );

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[2]),
        .in_data   (in_data),
        .out_ready (out_ready_c),
        .out_valid (out_valid_c),
        .out_data  (out_data_c),
        .cnt       (cnt_c)
    );

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_d (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[3]),
        .in_data   (in_data),
        .out_ready (out_ready_d),
        .out_valid (out_valid_d),
        .out_data  (out_data_d),
        .cnt       (cnt_d)
    );

endmodule

// File: doc/demux1x4_buf.md
# demux1x4_buf

Registered 1-to-4 demultiplexer with valid/ready handshake, the write-side counterpart of the 32-bit 4:1 result multiplexer in the CPU datapath. It accepts one 32-bit word per cycle on a single input channel and routes it, by a 2-bit control code, into one of four one-entry holding slots (A, B, C, D). Each slot drains independently to its own consumer. The block sits between the execute/write-back stage and four destination units. Per-slot transfer counters support debug and performance checks.

## Interface
Parameters:
- `WIDTH`, default 32: data width of the input and of every output slot.
- `CNT_W`, default 16: width of each per-slot transfer counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ctrl`  in  2  destination select: 2'b00→A, 2'b10→B, 2'b01→C, 2'b11→D.
- `in_valid`  in  1  input word valid.
- `in_data`  in  WIDTH  input word.
- `in_ready`  out  1  block accepts the word this cycle.
- `out_valid_a..d`  out  1 each  slot holds a word.
- `out_data_a..d`  out  WIDTH each  slot contents.
- `out_ready_a..d`  in  1 each  consumer takes the slot word this cycle.
- `cnt_a..cnt_d`  out  CNT_W each  count of words delivered from each slot (output handshakes).
- `busy`  out  1  OR of all four `out_valid_*`.

## Operation
- Each slot has a `full` flag and a data register. `out_valid_x = full_x`. `out_data_x = data_x`.
- `in_ready = !full[sel] | out_ready[sel]`, where `sel` is the slot decoded from `ctrl`. This path is combinational and depends on `ctrl` and the selected `out_ready`.
- Accept is `in_valid & in_ready`. On accept, the selected slot loads `in_data` and sets `full`.
- Drain is `full_x & out_ready_x`. On drain without a load, `full_x` clears and `data_x` holds its old value.
- Drain and load on the same slot in the same cycle: `full` stays 1, `data` takes the new word, and the counter increments.
- Non-selected slots are unaffected by `in_valid`, `in_data` and `ctrl`, and drain independently in the same cycle.
- `ctrl` and `in_data` are ignored when `in_valid` = 0. A producer holding `in_valid` must keep `ctrl` and `in_data` stable until accept.
- Counter `cnt_x` increments by 1 on every drain of slot x. It wraps from all-ones to 0 with no flag.
- `out_ready_x` asserted while `full_x` = 0 has no effect.

## Timing
- Reset (async assert, sync deassert by the clock edge): all `full` = 0, all data = 0, all counters = 0.
- At reset: `in_ready` = 1, `busy` = 0, all `out_valid_*` = 0, all `out_data_*` = 0, all `cnt_*` = 0.
- Latency: a word accepted at edge N is visible on `out_valid_x`/`out_data_x` after edge N. Earliest drain is edge N+1.
- Throughput: one word per cycle into a single slot when its consumer holds `out_ready` = 1.
- Reset asserted mid-transfer discards all held words immediately. Counters clear and no partial state survives.

## Structure
- Shared package `demux_pkg`:
  - slot codes `CH_A = 2'b00`, `CH_B = 2'b10`, `CH_C = 2'b01`, `CH_D = 2'b11`.
  - default `WIDTH` = 32.
  - These codes are the same encoding the 4:1 result multiplexer uses, and both blocks import them.
- Sub-module `demux_slot`: one-entry holding register with `full` flag, load/drain logic and transfer counter. It is instantiated four times.
- The top level contains the `ctrl` decode, the `in_ready` mux and the `busy` OR only.

## Test plan
- Reset then idle:
  - check `in_ready` = 1, `busy` = 0, all outputs 0.
  - assert `out_ready_a..d` = 1 with no input → all counters stay 0.
- Routing:
  - send 0x11111111 with `ctrl`=00, 0x22222222 with 10, 0x33333333 with 01, 0x44444444 with 11, all outputs stalled.
  - → slots A/B/C/D hold those values respectively; `busy` = 1.
  - a further word to slot A → `in_ready` = 0.
- Back-pressure: slot B full with `out_ready_b` = 0, `in_valid` = 1, `ctrl` = 10 → `in_ready` = 0 and B unchanged.
  - raise `out_ready_b` → same cycle `in_ready` = 1.
  - next edge: B holds the new word and `cnt_b` = 1.
- Streaming: 8 consecutive words 0..7 to slot C with `out_ready_c` = 1 → one drain per cycle, `cnt_c` = 8, last `out_data_c` = 7.
- Counter wrap: preload by 65535 drains on slot D → `cnt_d` = 0xFFFF; one more drain → 0x0000.
- Reset mid-operation: three slots full, pulse `rst_n` low between edges → outputs clear immediately, before the next edge.
